seg7_bcd_capture: RTL and testbench
===================================

SEG7_BCD_CAPTURE -- requirements
Module: seg7_bcd_capture

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive identical samples required before a digit is captured; legal range 2..15.
REQ-002 SHALL have parameter TIMEOUT, default 1024: cycles without a capture before the stale flag is raised; legal range 16..65535.
REQ-003 SHALL use one clock and an asynchronous active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port seg_n, input, 7 bits: active-low segments; bit0=a, bit1=b, ..., bit6=g.
REQ-007 SHALL have port dig_sel, input, 4 bits: one-hot active-high digit strobe; 0000 marks a blanking gap.
REQ-008 SHALL have port bcd, output, 16 bits: decoded digits; digit i occupies [4i+3:4i].
REQ-009 SHALL have port blank, output, 4 bits: digit i was received as all segments off (7'h7F).
REQ-010 SHALL have port err, output, 4 bits: digit i was received as an unrecognised pattern.
REQ-011 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when bcd/blank/err update.
REQ-012 SHALL have port stale, output, 1 bit: no capture within TIMEOUT cycles.

Function
REQ-013 SHALL register seg_n and dig_sel once at every clk edge; all later decisions use these registered samples.
REQ-014 SHALL decode a seg_n pattern to a BCD value using this fixed table: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h03, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-015 SHALL decode pattern 7'h7F as a blank digit: value 4'h0 and blank=1.
REQ-016 SHALL decode any other pattern as value 4'hF with err=1.
REQ-017 SHALL keep a run counter of consecutive identical (dig_sel, seg_n) samples that saturates at STABLE_CYC.
REQ-018 SHALL reload the run counter to 1 when the sample differs from the previous sample and dig_sel is one-hot.
REQ-019 SHALL clear the run counter to 0 when dig_sel is 0000 or not one-hot; such samples are never captured.
REQ-020 SHALL capture a digit exactly once per run, on the edge at which the run counter reaches STABLE_CYC. The capture writes that digit's shadow value, blank and err bits and sets its bit in a 4-bit frame mask.
REQ-021 SHALL NOT capture again while the run counter is held at saturation.
REQ-022 SHALL overwrite the shadow value when a digit whose mask bit is already set is captured again (latest wins) and leave the mask unchanged.
REQ-023 SHALL, on the capture edge that makes the mask 1111, load bcd/blank/err from the shadow registers including the newly captured digit and clear the mask on the same edge.
REQ-024 SHALL assert frame_valid for exactly the one cycle following that capture edge.
REQ-025 SHALL hold bcd/blank/err unchanged between frames; partial frames never reach the outputs.
REQ-026 SHALL clear the idle counter on every capture and otherwise increment it, saturating.
REQ-027 SHALL, when the idle counter reaches TIMEOUT, set stale=1 and clear the frame mask.
REQ-028 SHALL clear stale on the frame_valid cycle; if a capture and the timeout occur on the same edge, the capture wins and stale is not set.
REQ-029 SHALL add 1 cycle of latency from the input pins to the registered samples; frame_valid rises STABLE_CYC+1 cycles after the first pin-level sample of the completing digit.

Reset
REQ-030 SHALL, while rst is high, asynchronously force bcd=16'h0000, blank=4'hF, err=4'h0, frame_valid=0, stale=0.
REQ-031 SHALL, while rst is high, asynchronously clear the mask, shadow registers, run counter, idle counter and input samples.
REQ-032 SHALL discard any frame in progress when reset is asserted mid-frame; no frame_valid is issued for it after release.

Verification
REQ-033 SHALL be tested with: scan digits 0..3 showing 7'h30,7'h12,7'h03,7'h10, 6 cycles each -> frame_valid once, bcd=16'h9653, blank=0, err=0.
REQ-034 SHALL be tested with: digit 2 held at 3 cycles then changed (STABLE_CYC=4) -> no capture for digit 2 and no frame_valid until digit 2 is re-held for 4 or more cycles.
REQ-035 SHALL be tested with: digit 1 = 7'h7F, digit 3 = 7'h55 -> blank=4'b0010, err=4'b1000, bcd[15:12]=4'hF.
REQ-036 SHALL be tested with: dig_sel=4'b0110 for 20 cycles -> no capture and the run counter stays 0.
REQ-037 SHALL be tested with: 3 digits captured, then no strobes for 1024 cycles -> stale=1; a full new frame then yields frame_valid and stale=0.
REQ-038 SHALL be tested with: rst pulsed after 2 digits of a frame -> outputs at reset values; the next full frame produces exactly one frame_valid.

Source files
------------

// File: rtl/seg7_bcd_capture.sv
// Captures a multiplexed active-low 7-segment display scan and decodes it into
// four BCD digits, publishing only complete frames and flagging a stalled scan.
module seg7_bcd_capture #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_sel,
    output logic [15:0] bcd,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        stale
);

    localparam logic [3:0]  STABLE_C  = 4'(STABLE_CYC);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    // Returns {err, blank, value[3:0]} for one active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'h40:   res = {2'b00, 4'd0};
            7'h79:   res = {2'b00, 4'd1};
            7'h24:   res = {2'b00, 4'd2};
            7'h30:   res = {2'b00, 4'd3};
            7'h19:   res = {2'b00, 4'd4};
            7'h12:   res = {2'b00, 4'd5};
            7'h03:   res = {2'b00, 4'd6};
            7'h78:   res = {2'b00, 4'd7};
            7'h00:   res = {2'b00, 4'd8};
            7'h10:   res = {2'b00, 4'd9};
            7'h7F:   res = {2'b01, 4'h0};
            default: res = {2'b10, 4'hF};
        endcase
        return res;
    endfunction

    function automatic logic is_onehot(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] s);
        logic [1:0] idx;
        case (s)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [6:0]  seg_r;
    logic [3:0]  sel_r;
    logic [6:0]  prev_seg_r;
    logic [3:0]  prev_sel_r;
    logic [3:0]  run_cnt_r;
    logic [15:0] idle_r;
    logic [3:0]  mask_r;
    logic [15:0] shadow_val_r;
    logic [3:0]  shadow_blank_r;
    logic [3:0]  shadow_err_r;

    logic        onehot_s;
    logic        same_s;
    logic [3:0]  run_next_s;
    logic        capture_s;
    logic [5:0]  dec_s;
    logic [1:0]  idx_s;
    logic [15:0] val_next_s;
    logic [3:0]  blank_next_s;
    logic [3:0]  err_next_s;
    logic [3:0]  mask_or_s;
    logic        frame_done_s;
    logic        timeout_s;
    logic [15:0] idle_next_s;
    logic [3:0]  mask_next_s;

    // Input sampling stage plus the previous sample used for run detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r      <= 7'h00;
            sel_r      <= 4'b0000;
            prev_seg_r <= 7'h00;
            prev_sel_r <= 4'b0000;
        end else begin
            seg_r      <= seg_n;
            sel_r      <= dig_sel;
            prev_seg_r <= seg_r;
            prev_sel_r <= sel_r;
        end
    end

    // Run tracking, capture decision, shadow update, frame mask and idle timer.
    always_comb begin
        onehot_s     = is_onehot(sel_r);
        same_s       = (sel_r == prev_sel_r) && (seg_r == prev_seg_r);
        run_next_s   = 4'd0;
        dec_s        = decode_seg(seg_r);
        idx_s        = sel_index(sel_r);
        val_next_s   = shadow_val_r;
        blank_next_s = shadow_blank_r;
        err_next_s   = shadow_err_r;
        idle_next_s  = idle_r;
        mask_next_s  = mask_r;

        if (!onehot_s) begin
            run_next_s = 4'd0;
        end else if (!same_s) begin
            run_next_s = 4'd1;
        end else if (run_cnt_r >= STABLE_C) begin
            run_next_s = STABLE_C;
        end else begin
            run_next_s = run_cnt_r + 4'd1;
        end

        // A capture fires only on the transition into saturation, never while held there.
        capture_s = onehot_s && (run_next_s == STABLE_C) && (run_cnt_r != STABLE_C);

        if (capture_s) begin
            val_next_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
            blank_next_s[idx_s]             = dec_s[4];
            err_next_s[idx_s]               = dec_s[5];
        end else begin
            val_next_s   = shadow_val_r;
            blank_next_s = shadow_blank_r;
            err_next_s   = shadow_err_r;
        end

        mask_or_s    = mask_r | sel_r;
        frame_done_s = capture_s && (mask_or_s == 4'hF);
        timeout_s    = !capture_s && (idle_r >= (TIMEOUT_C - 16'd1));

        if (capture_s) begin
            idle_next_s = 16'd0;
        end else if (timeout_s) begin
            idle_next_s = TIMEOUT_C;
        end else begin
            idle_next_s = idle_r + 16'd1;
        end

        if (frame_done_s) begin
            mask_next_s = 4'b0000;
        end else if (capture_s) begin
            mask_next_s = mask_or_s;
        end else if (timeout_s) begin
            mask_next_s = 4'b0000;
        end else begin
            mask_next_s = mask_r;
        end
    end

    // Capture state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_r      <= 4'd0;
            idle_r         <= 16'd0;
            mask_r         <= 4'b0000;
            shadow_val_r   <= 16'h0000;
            shadow_blank_r <= 4'b0000;
            shadow_err_r   <= 4'b0000;
        end else begin
            run_cnt_r      <= run_next_s;
            idle_r         <= idle_next_s;
            mask_r         <= mask_next_s;
            shadow_val_r   <= val_next_s;
            shadow_blank_r <= blank_next_s;
            shadow_err_r   <= err_next_s;
        end
    end

    // Published frame and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd         <= 16'h0000;
            blank       <= 4'hF;
            err         <= 4'h0;
            frame_valid <= 1'b0;
            stale       <= 1'b0;
        end else begin
            frame_valid <= frame_done_s;
            if (frame_done_s) begin
                bcd   <= val_next_s;
                blank <= blank_next_s;
                err   <= err_next_s;
                stale <= 1'b0;
            end else if (timeout_s) begin
                stale <= 1'b1;
            end else begin
                stale <= stale;
            end
        end
    end

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Directed bench for seg7_bcd_capture: a history-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_seg7_bcd_capture;

    localparam int S  = 4;
    localparam int TO = 1024;
    localparam logic [6:0] PAT_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h03, 7'h78, 7'h00, 7'h10};

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [6:0]  seg_n   = 7'h7F;
    logic [3:0]  dig_sel = 4'b0000;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        frame_valid;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int f0     = 0;

    seg7_bcd_capture #(.STABLE_CYC(S), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .bcd         (bcd),
        .blank       (blank),
        .err         (err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // Reference model state: pin samples seen so far and the frame being assembled.
    logic [10:0] hist [$];
    logic [3:0]  m_val [4];
    logic [3:0]  m_blank_sh = 4'h0;
    logic [3:0]  m_err_sh   = 4'h0;
    logic [3:0]  m_mask     = 4'h0;
    logic [15:0] m_bcd      = 16'h0000;
    logic [3:0]  m_blank    = 4'hF;
    logic [3:0]  m_err      = 4'h0;
    logic        m_fv       = 1'b0;
    logic        m_stale    = 1'b0;
    int          m_since    = 0;

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 10; k++) begin
            if (PAT_TBL[k] == p) return {2'b00, 4'(k)};
        end
        if (p == 7'h7F) return 6'b01_0000;
        return 6'b10_1111;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 4; k++) m_val[k] = 4'h0;
        m_blank_sh = 4'h0;
        m_err_sh   = 4'h0;
        m_mask     = 4'h0;
        m_bcd      = 16'h0000;
        m_blank    = 4'hF;
        m_err      = 4'h0;
        m_fv       = 1'b0;
        m_stale    = 1'b0;
        m_since    = 0;
    endtask

    task automatic model_step();
        logic [10:0] last;
        logic [5:0]  dv;
        bit          cap;
        bit          run_ok;
        int          n;
        int          d;
        cap  = 1'b0;
        d    = 0;
        last = 11'h000;
        n    = hist.size();
        // A digit is taken when its last S samples are identical and the run began exactly S samples ago.
        if (n >= S) begin
            last = hist[n-1];
            if ($countones(last[10:7]) == 1) begin
                run_ok = 1'b1;
                for (int i = 1; i < S; i++) begin
                    if (hist[n-1-i] != last) run_ok = 1'b0;
                end
                if (run_ok && (n == S || hist[n-1-S] != last)) cap = 1'b1;
            end
        end
        m_fv = 1'b0;
        if (cap) begin
            for (int k = 0; k < 4; k++) if (last[7+k]) d = k;
            dv            = ref_decode(last[6:0]);
            m_val[d]      = dv[3:0];
            m_blank_sh[d] = dv[4];
            m_err_sh[d]   = dv[5];
            m_mask[d]     = 1'b1;
            m_since       = 0;
            if (m_mask == 4'hF) begin
                m_bcd   = {m_val[3], m_val[2], m_val[1], m_val[0]};
                m_blank = m_blank_sh;
                m_err   = m_err_sh;
                m_mask  = 4'h0;
                m_fv    = 1'b1;
                m_stale = 1'b0;
            end
        end else begin
            m_since++;
            if (m_since >= TO) begin
                m_since = TO;
                m_stale = 1'b1;
                m_mask  = 4'h0;
            end
        end
        hist.push_back({dig_sel, seg_n});
        if (hist.size() > S + 1) void'(hist.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({bcd, blank, err, frame_valid, stale} !== {m_bcd, m_blank, m_err, m_fv, m_stale}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time,
                         {bcd, blank, err, frame_valid, stale}, {m_bcd, m_blank, m_err, m_fv, m_stale});
            end
            if (frame_valid === 1'b1) fv_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic show(input logic [3:0] sel, input logic [6:0] pat, input int n);
        dig_sel = sel;
        seg_n   = pat;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        show(4'b0000, 7'h7F, n);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bcd"},   32'(bcd),         32'h0000_0000);
        check({tag, "_blank"}, 32'(blank),       32'h0000_000F);
        check({tag, "_err"},   32'(err),         32'h0000_0000);
        check({tag, "_fv"},    32'(frame_valid), 32'h0000_0000);
        check({tag, "_stale"}, 32'(stale),       32'h0000_0000);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        idle(2);

        // Basic frame: 3,5,6,9 on digits 0..3.
        f0 = fv_cnt;
        show(4'b0001, 7'h30, 6);
        show(4'b0010, 7'h12, 6);
        show(4'b0100, 7'h03, 6);
        show(4'b1000, 7'h10, 6);
        idle(2);
        check("t033_fv",    32'(fv_cnt - f0), 32'd1);
        check("t033_bcd",   32'(bcd),         32'h0000_9653);
        check("t033_blank", 32'(blank),       32'h0000_0000);
        check("t033_err",   32'(err),         32'h0000_0000);

        // Digit 2 held one cycle short of stable, then completed later.
        f0 = fv_cnt;
        show(4'b0001, 7'h40, 6);
        show(4'b0010, 7'h79, 6);
        show(4'b0100, 7'h24, 3);
        show(4'b1000, 7'h30, 6);
        idle(2);
        check("t034_nofv", 32'(fv_cnt - f0), 32'd0);
        check("t034_hold", 32'(bcd),         32'h0000_9653);
        show(4'b0100, 7'h19, 6);
        idle(2);
        check("t034_fv",  32'(fv_cnt - f0), 32'd1);
        check("t034_bcd", 32'(bcd),         32'h0000_3410);

        // Recapture overwrites digit 0; blank digit 1; bad pattern on digit 3.
        f0 = fv_cnt;
        show(4'b0001, 7'h79, 6);
        show(4'b0001, 7'h40, 6);
        show(4'b0010, 7'h7F, 6);
        show(4'b0100, 7'h79, 6);
        show(4'b1000, 7'h55, 6);
        idle(2);
        check("t035_fv",    32'(fv_cnt - f0), 32'd1);
        check("t035_bcd",   32'(bcd),         32'h0000_F100);
        check("t035_blank", 32'(blank),       32'h0000_0002);
        check("t035_err",   32'(err),         32'h0000_0008);

        // Non-one-hot strobe never starts a run.
        f0 = fv_cnt;
        dig_sel = 4'b0110;
        seg_n   = 7'h30;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t036_run", 32'(dut.run_cnt_r), 32'd0);
        end
        idle(2);
        check("t036_nofv", 32'(fv_cnt - f0), 32'd0);

        // Three digits then silence until stale; a fresh full frame recovers.
        f0 = fv_cnt;
        show(4'b0001, 7'h10, 6);
        show(4'b0010, 7'h10, 6);
        show(4'b0100, 7'h10, 6);
        idle(1000);
        check("t037_not_yet", 32'(stale), 32'd0);
        idle(30);
        check("t037_stale", 32'(stale),       32'd1);
        check("t037_nofv",  32'(fv_cnt - f0), 32'd0);
        show(4'b0001, 7'h12, 6);
        show(4'b0010, 7'h03, 6);
        show(4'b0100, 7'h78, 6);
        show(4'b1000, 7'h00, 6);
        idle(2);
        check("t037_fv",    32'(fv_cnt - f0), 32'd1);
        check("t037_clear", 32'(stale),       32'd0);
        check("t037_bcd",   32'(bcd),         32'h0000_8765);

        // Reset mid-frame discards the partial digits.
        show(4'b0001, 7'h40, 6);
        show(4'b0010, 7'h79, 6);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values("t038_in_rst");
        f0  = fv_cnt;
        rst = 1'b0;
        idle(2);
        check_reset_values("t038_after");
        show(4'b0100, 7'h78, 6);
        show(4'b1000, 7'h03, 6);
        idle(2);
        check("t038_partial", 32'(fv_cnt - f0), 32'd0);
        show(4'b0001, 7'h10, 6);
        show(4'b0010, 7'h00, 6);
        idle(2);
        check("t038_fv",  32'(fv_cnt - f0), 32'd1);
        check("t038_bcd", 32'(bcd),         32'h0000_6789);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
